processador_pio_in: RTL

PROCESSADOR_PIO_IN -- requirements
Module: processador_pio_in

---
 rtl/processador_pio_pkg.sv | 13 +
 rtl/processador_pio_in_if.sv | 20 ++
 rtl/processador_pio_sync.sv | 26 ++
 rtl/processador_pio_in.sv | 92 +++++++++
 4 files changed

// File: rtl/processador_pio_pkg.sv
// Shared constants for the parallel input port: register map and edge-type encodings.
package processador_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/processador_pio_in_if.sv
// Avalon-MM slave bus of the parallel input port (zero wait states, zero read latency).
interface processador_pio_in_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/processador_pio_sync.sv
// Multi-flop synchronizer bringing asynchronous inputs into the clk domain.
module processador_pio_sync #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Stage 0 samples d; the highest index is the settled output.
    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;

    // NOTE: sequential state uses non-blocking assignments so every stage samples its pre-edge value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/processador_pio_in.sv
// Parallel input port with edge capture, write-1-to-clear capture register and masked level IRQ.
module processador_pio_in
    import processador_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    processador_pio_in_if.slave  avs,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("processador_pio_in: WIDTH must be 1..32");
    end
    if (EDGE_TYPE < EDGE_RISE || EDGE_TYPE > EDGE_ANY) begin : g_bad_edge
        $error("processador_pio_in: EDGE_TYPE must be 0, 1 or 2");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
        $error("processador_pio_in: SYNC_STAGES must be 2..3");
    end

    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic             irq_q, irq_d;
    logic [WIDTH-1:0] edge_det;
    logic             wr_en;
    logic             unused_wdata;

    processador_pio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (in_port),
        .q     (sync_q)
    );

    assign wr_en        = avs.chipselect & ~avs.write_n;
    assign unused_wdata = ^avs.writedata;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        edge_det  = '0;
        irqmask_d = irqmask_q;
        edgecap_d = edgecap_q;

        if (EDGE_TYPE == EDGE_RISE)      edge_det = sync_q & ~prev_q;
        else if (EDGE_TYPE == EDGE_FALL) edge_det = ~sync_q & prev_q;
        else                             edge_det = sync_q ^ prev_q;

        if (wr_en && avs.address == ADDR_IRQMASK) irqmask_d = avs.writedata[WIDTH-1:0];
        if (wr_en && avs.address == ADDR_EDGECAP) edgecap_d = edgecap_q & ~avs.writedata[WIDTH-1:0];
        // Set is applied after the clear so a same-cycle edge survives a write-1-to-clear.
        edgecap_d = edgecap_d | edge_det;

        irq_d = |(edgecap_q & irqmask_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q    <= '0;
            irqmask_q <= '0;
            edgecap_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            prev_q    <= sync_q;
            irqmask_q <= irqmask_d;
            edgecap_q <= edgecap_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        avs.readdata = '0;
        case (avs.address)
            ADDR_DATA:    avs.readdata[WIDTH-1:0] = sync_q;
            ADDR_IRQMASK: avs.readdata[WIDTH-1:0] = irqmask_q;
            ADDR_EDGECAP: avs.readdata[WIDTH-1:0] = edgecap_q;
            default:      avs.readdata = '0;
        endcase
    end

    assign irq = irq_q;

endmodule
